// File: rtl/ifid_skid_stage.sv
// IF/ID pipeline stage: valid/ready handshake with a 2-entry skid buffer, flush squash and NOP fill.
// Optional IFID_STATS_EN adds saturating stall/flush counters (stall_cycles, flush_count).
module ifid_skid_stage #(
   parameter int                PC_W     = 32,
   parameter int                INST_W   = 32,
   parameter logic [INST_W-1:0] NOP_INST = {INST_W{1'b0}}
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PC_W-1:0]   in_pc,
   input  logic [INST_W-1:0] in_inst,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PC_W-1:0]   out_pc,
   output logic [INST_W-1:0] out_inst,
   output logic [1:0]        occupancy
`ifdef IFID_STATS_EN
   ,
   output logic [15:0]       stall_cycles,
   output logic [15:0]       flush_count
`endif
);

   // Encoding doubles as the occupancy count.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      HEAD  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t              state, state_nxt;
   logic                acc, pop;
   logic                ld_head_in, ld_head_skid, ld_skid;
   logic [PC_W-1:0]     head_pc, skid_pc;
   logic [INST_W-1:0]   head_inst, skid_inst;

   // Ready/valid are pure decodes of the state register, so no path from out_ready to in_ready.
   assign in_ready  = (state != FULL);
   assign out_valid = (state != EMPTY);
   assign occupancy = state;
   assign acc       = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign out_pc    = head_pc;
   assign out_inst  = out_valid ? head_inst : NOP_INST;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= EMPTY;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      ld_head_in   = 1'b0;
      ld_head_skid = 1'b0;
      ld_skid      = 1'b0;
      case (state)
         EMPTY: if (acc) begin
            state_nxt  = HEAD;
            ld_head_in = 1'b1;
         end
         HEAD: begin
            if (acc && pop) begin
               ld_head_in = 1'b1;
            end else if (acc) begin
               state_nxt = FULL;
               ld_skid   = 1'b1;
            end else if (pop) begin
               state_nxt = EMPTY;
            end
         end
         FULL: if (pop) begin
            state_nxt    = HEAD;
            ld_head_skid = 1'b1;
         end
         default: state_nxt = EMPTY;
      endcase
      // Flush wins: a same-edge accept is dropped, a same-edge pop already happened downstream.
      if (flush) begin
         state_nxt    = EMPTY;
         ld_head_in   = 1'b0;
         ld_head_skid = 1'b0;
         ld_skid      = 1'b0;
      end
   end

   // Payload only loads on accept, so junk on in_* while idle never lands in storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_pc   <= '0;
         head_inst <= NOP_INST;
         skid_pc   <= '0;
         skid_inst <= NOP_INST;
      end else begin
         if (ld_head_in) begin
            head_pc   <= in_pc;
            head_inst <= in_inst;
         end else if (ld_head_skid) begin
            head_pc   <= skid_pc;
            head_inst <= skid_inst;
         end
         if (ld_skid) begin
            skid_pc   <= in_pc;
            skid_inst <= in_inst;
         end
      end
   end

`ifdef IFID_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if (out_valid && !out_ready && stall_cycles != 16'hFFFF)
            stall_cycles <= stall_cycles + 16'd1;
         if (flush && occupancy != 2'd0 && flush_count != 16'hFFFF)
            flush_count <= flush_count + 16'd1;
      end
   end
`endif

endmodule
